wishbone_master: RTL

Wishbone classic single-cycle bus initiator that converts CPU load/store requests into Wishbone read/write cycles for the SoC memory and peripheral slaves. Handles byte/half/word sizing with byte-lane selects, right-aligns and zero-extends read data, and reports misalignment, slave error and bus timeout. It sits between the core's load/store unit and the shared Wishbone slave bus.

---
 rtl/wishbone_master.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wishbone_master.sv
// rtl/wishbone_master.sv - Wishbone classic single-cycle bus initiator
// Converts CPU load/store requests into sized, lane-selected Wishbone cycles.
module wishbone_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        REQ_VALID_I,
    output logic        REQ_READY_O,
    input  logic        REQ_WE_I,
    input  logic [1:0]  REQ_SIZE_I,
    input  logic [31:0] REQ_ADR_I,
    input  logic [31:0] REQ_DAT_I,
    output logic        RSP_VALID_O,
    output logic [31:0] RSP_DAT_O,
    output logic        RSP_ERR_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic        ERR_I
);

    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [29:0] wadr_q;
    logic [31:0] wdat_q;
    logic [3:0]  sel_q;
    logic [15:0] cnt_q;
    logic [31:0] rdat_q;
    logic        err_q;

    logic        req_legal;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic [31:0] rd_shift;
    logic [31:0] rd_data;
    logic        in_bus;
    logic        in_resp;

    always_comb begin
        req_legal = 1'b0;
        req_sel   = 4'b1111;
        req_dat   = REQ_DAT_I;
        case (REQ_SIZE_I)
            2'b00: begin
                req_legal = 1'b1;
                req_sel   = 4'b0001 << REQ_ADR_I[1:0];
                req_dat   = {4{REQ_DAT_I[7:0]}};
            end
            2'b01: begin
                req_legal = ~REQ_ADR_I[0];
                req_sel   = 4'b0011 << REQ_ADR_I[1:0];
                req_dat   = {2{REQ_DAT_I[15:0]}};
            end
            2'b10: req_legal = (REQ_ADR_I[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // Load data is right-aligned from the addressed lane and zero-extended to size.
    always_comb begin
        rd_shift = DAT_I >> {off_q, 3'b000};
        case (size_q)
            2'b00:   rd_data = {24'b0, rd_shift[7:0]};
            2'b01:   rd_data = {16'b0, rd_shift[15:0]};
            default: rd_data = rd_shift;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (REQ_VALID_I) state_nxt = req_legal ? BUS : RESP;
            BUS:  if (ERR_I || ACK_I || cnt_q == TMAX) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            we_q   <= 1'b0;
            size_q <= 2'b00;
            off_q  <= 2'b00;
            wadr_q <= 30'b0;
            wdat_q <= 32'b0;
            sel_q  <= 4'b0;
            cnt_q  <= 16'b0;
            rdat_q <= 32'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (REQ_VALID_I) begin
                    we_q   <= REQ_WE_I;
                    size_q <= REQ_SIZE_I;
                    off_q  <= REQ_ADR_I[1:0];
                    wadr_q <= REQ_ADR_I[31:2];
                    wdat_q <= req_dat;
                    sel_q  <= req_sel;
                    cnt_q  <= 16'b0;
                    rdat_q <= 32'b0;
                    err_q  <= ~req_legal;
                end
                BUS: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (ERR_I) begin
                        err_q <= 1'b1;
                    end else if (ACK_I) begin
                        if (!we_q) rdat_q <= rd_data;
                    end else if (cnt_q == TMAX) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus and response outputs are gated by state so they read zero when inactive.
    assign in_bus      = (state == BUS);
    assign in_resp     = (state == RESP);
    assign REQ_READY_O = (state == IDLE) && RST_I;
    assign CYC_O       = in_bus;
    assign STB_O       = in_bus;
    assign WE_O        = in_bus & we_q;
    assign ADR_O       = in_bus ? {wadr_q, 2'b00} : 32'b0;
    assign DAT_O       = in_bus ? wdat_q : 32'b0;
    assign SEL_O       = in_bus ? sel_q : 4'b0;
    assign RSP_VALID_O = in_resp;
    assign RSP_DAT_O   = in_resp ? rdat_q : 32'b0;
    assign RSP_ERR_O   = in_resp & err_q;

endmodule
